// File: rtl/key_uart_tx.sv
// Counts key-press pulses and sends each updated count as one UART 8N1 frame, LSB first.
// Latency: flag in cycle N drives the start bit from cycle N+1. No backpressure; one press is held pending while busy.
module key_uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       flag,
    output logic       tx,
    output logic       busy,
    output logic [7:0] press_cnt
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD;
    localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             pending_q, pending_d;
    logic [7:0]       press_q, press_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             baud_done;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            pending_q <= 1'b0;
            press_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            pending_q <= pending_d;
            press_q   <= press_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        pending_d = pending_q;
        press_d   = press_q + 8'(flag);
        baud_done = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                // press_d already includes a press arriving this cycle
                if (flag || pending_q) begin
                    state_d   = START;
                    shift_d   = press_d;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    bit_d     = '0;
                end
            end
            START: begin
                if (flag) pending_d = 1'b1;
                if (baud_done) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (flag) pending_d = 1'b1;
                if (baud_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit, no idle gap
                    if (pending_q || flag) begin
                        state_d   = START;
                        shift_d   = press_d;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (flag) pending_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign press_cnt = press_q;

endmodule

// File: tb/tb_key_uart_tx.sv
// Bench for key_uart_tx: randomized and directed presses checked against a frame-timing model.
module tb_key_uart_tx;

    localparam int BCM   = 10;
    localparam int FRAME = 10 * BCM;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       flag    = 1'b0;
    logic       tx;
    logic       busy;
    logic [7:0] press_cnt;

    int checks = 0;
    int fails  = 0;

    key_uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .flag      (flag),
        .tx        (tx),
        .busy      (busy),
        .press_cnt (press_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Frame-level model: a frame is FRAME cycles from fstart; bit slot = offset / BCM.
    int         m_cyc    = 0;
    int         m_fstart = 0;
    logic       m_active = 1'b0;
    logic       m_pend   = 1'b0;
    logic [7:0] m_cnt    = 8'd0;
    logic [7:0] m_fbyte  = 8'd0;

    task automatic model_reset();
        m_active = 1'b0;
        m_pend   = 1'b0;
        m_cnt    = 8'd0;
    endtask

    task automatic model_edge(input logic f);
        int         t;
        logic [7:0] nc;
        t  = m_cyc;
        nc = m_cnt + 8'(f);
        if (!m_active) begin
            if (f) begin
                m_active = 1'b1;
                m_fstart = t + 1;
                m_fbyte  = nc;
            end
        end else if (t == m_fstart + FRAME - 1) begin
            if (m_pend || f) begin
                m_fstart = t + 1;
                m_fbyte  = nc;
                m_pend   = 1'b0;
            end else begin
                m_active = 1'b0;
            end
        end else if (f) begin
            m_pend = 1'b1;
        end
        m_cnt = nc;
        m_cyc = t + 1;
    endtask

    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = (m_cyc - m_fstart) / BCM;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_fbyte[k-1];
        return 1'b1;
    endfunction

    // Drive flag for one cycle; returns at the following negedge with the model advanced.
    task automatic step(input logic f);
        flag = f;
        @(posedge sys_clk);
        model_edge(f);
        @(negedge sys_clk);
        flag = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if ({tx, busy, press_cnt} !== {1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL reset_hold: tx=%b busy=%b cnt=%h want 1 0 00", tx, busy, press_cnt);
        end
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step(1'b0);
            checks++;
            if ({tx, busy, press_cnt} !== {1'b1, 1'b0, 8'h00}) begin
                fails++;
                $display("FAIL reset_idle[%0d]: tx=%b busy=%b cnt=%h want 1 0 00", i, tx, busy, press_cnt);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] rx;
        logic       s [FRAME+1];
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0);
        for (int j = 0; j <= FRAME; j++) begin
            step(j == 0);
            s[j] = tx;
            checks++;
            if (tx !== exp_tx() || busy !== m_active || press_cnt !== m_cnt) begin
                fails++;
                $display("FAIL single[%0d]: tx=%b busy=%b cnt=%h want %b %b %h", j, tx, busy, press_cnt, exp_tx(), m_active, m_cnt);
            end
        end
        for (int k = 0; k < 8; k++) rx[k] = s[BCM*(k+1) + BCM/2];
        checks++;
        if (rx !== 8'h01 || s[0] !== 1'b0 || s[BCM-1] !== 1'b0 || s[FRAME-1] !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_frame: byte=%h start=%b%b stop=%b busy_end=%b want 01 00 1 0", rx, s[0], s[BCM-1], s[FRAME-1], busy);
        end
    endtask

    task automatic test_back_to_back();
        int         busy_cycles;
        logic [7:0] rx;
        logic       s [260];
        do_reset();
        busy_cycles = 0;
        for (int i = 0; i < 260; i++) begin
            step(i == 0 || i == 45 || i == 60 || i == 75);
            s[i] = tx;
            if (busy) busy_cycles++;
            checks++;
            if (tx !== exp_tx() || busy !== m_active || press_cnt !== m_cnt) begin
                fails++;
                $display("FAIL b2b[%0d]: tx=%b busy=%b cnt=%h want %b %b %h", i, tx, busy, press_cnt, exp_tx(), m_active, m_cnt);
            end
        end
        for (int k = 0; k < 8; k++) rx[k] = s[FRAME + BCM*(k+1) + BCM/2];
        checks++;
        if (busy_cycles != 2 * FRAME || rx !== 8'h04 || press_cnt !== 8'h04 || s[FRAME] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_frames: busy_cycles=%0d byte=%h cnt=%h start=%b want 200 04 04 0", busy_cycles, rx, press_cnt, s[FRAME]);
        end
    endtask

    task automatic test_last_stop();
        logic [7:0] rx;
        logic       s [FRAME+1];
        do_reset();
        step(1'b1);
        for (int i = 1; i < FRAME; i++) step(1'b0);
        for (int j = 0; j <= FRAME; j++) begin
            step(j == 0);
            s[j] = tx;
            checks++;
            if (tx !== exp_tx() || busy !== m_active || press_cnt !== m_cnt) begin
                fails++;
                $display("FAIL last_stop[%0d]: tx=%b busy=%b cnt=%h want %b %b %h", j, tx, busy, press_cnt, exp_tx(), m_active, m_cnt);
            end
        end
        for (int k = 0; k < 8; k++) rx[k] = s[BCM*(k+1) + BCM/2];
        checks++;
        if (s[0] !== 1'b0 || rx !== 8'h02 || busy !== 1'b0) begin
            fails++;
            $display("FAIL last_stop_frame: start=%b byte=%h busy_end=%b want 0 02 0", s[0], rx, busy);
        end
    endtask

    task automatic test_wrap();
        int         n;
        logic [7:0] rx;
        logic       s [FRAME];
        do_reset();
        for (int i = 0; i < 255; i++) step(1'b1);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            step(1'b0);
            n++;
            checks++;
            if (tx !== exp_tx() || busy !== m_active || press_cnt !== m_cnt) begin
                fails++;
                $display("FAIL wrap_drain[%0d]: tx=%b busy=%b cnt=%h want %b %b %h", n, tx, busy, press_cnt, exp_tx(), m_active, m_cnt);
            end
        end
        checks++;
        if (busy !== 1'b0 || press_cnt !== 8'hFF) begin
            fails++;
            $display("FAIL wrap_preload: busy=%b cnt=%h want 0 ff", busy, press_cnt);
        end
        for (int j = 0; j < FRAME; j++) begin
            step(j == 0);
            s[j] = tx;
        end
        for (int k = 0; k < 8; k++) rx[k] = s[BCM*(k+1) + BCM/2];
        checks++;
        if (press_cnt !== 8'h00 || rx !== 8'h00 || s[0] !== 1'b0 || s[FRAME-1] !== 1'b1) begin
            fails++;
            $display("FAIL wrap_frame: cnt=%h byte=%h start=%b stop=%b want 00 00 0 1", press_cnt, rx, s[0], s[FRAME-1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        logic       s [FRAME+1];
        do_reset();
        step(1'b1);
        for (int i = 0; i < 4 * BCM; i++) step(1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, busy, press_cnt} !== {1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL reset_mid: tx=%b busy=%b cnt=%h want 1 0 00", tx, busy, press_cnt);
        end
        model_reset();
        @(negedge sys_clk);
        rst_n = 1'b1;
        for (int j = 0; j <= FRAME; j++) begin
            step(j == 0);
            s[j] = tx;
            checks++;
            if (tx !== exp_tx() || busy !== m_active || press_cnt !== m_cnt) begin
                fails++;
                $display("FAIL after_reset[%0d]: tx=%b busy=%b cnt=%h want %b %b %h", j, tx, busy, press_cnt, exp_tx(), m_active, m_cnt);
            end
        end
        for (int k = 0; k < 8; k++) rx[k] = s[BCM*(k+1) + BCM/2];
        checks++;
        if (rx !== 8'h01 || s[0] !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_frame: byte=%h start=%b busy_end=%b want 01 0 0", rx, s[0], busy);
        end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 3);
            checks++;
            if (tx !== exp_tx() || busy !== m_active || press_cnt !== m_cnt) begin
                fails++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: tx=%b busy=%b cnt=%h want %b %b %h", i, tx, busy, press_cnt, exp_tx(), m_active, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_last_stop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
